// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline constants: ALU op encodings, forwarding codes and the EX control vector.
// The all-zero control vector doubles as the bubble/NOP pattern.
package id_ex_hazard_reg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A non-valid slot must never write the register file or touch memory.
    function automatic ctrl_t kill_side_effects(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detector.sv
// Load-use hazard detector: a load in EX whose rd feeds the instruction in ID.
// Purely combinational; a flush cancels the stall since ID is being discarded.
module load_use_detector
    import id_ex_hazard_reg_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  id_valid_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  flush_i,
    output logic                  stall_o
);

    logic load_in_ex;
    logic rs1_hit;
    logic rs2_hit;

    assign load_in_ex = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != '0);
    assign rs1_hit    = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
    assign stall_o    = ~flush_i & load_in_ex & id_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion and
// wrapping bubble/flush performance counters.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  id_mem_to_reg_i,
    input  logic                  id_alu_src_i,
    input  logic                  id_branch_i,
    input  logic                  id_jump_i,
    input  logic [ALU_OP_W-1:0]   id_alu_op_i,
    output logic                  ex_valid_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_rs1_data_o,
    output logic [XLEN-1:0]       ex_rs2_data_o,
    output logic [XLEN-1:0]       ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_mem_to_reg_o,
    output logic                  ex_alu_src_o,
    output logic                  ex_branch_o,
    output logic                  ex_jump_o,
    output logic [ALU_OP_W-1:0]   ex_alu_op_o,
    output logic                  load_use_stall_o,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic [CNT_W-1:0]      bubble_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        ctrl_t                 ctrl;
    } ex_stage_t;

    // An all-zero slot: forwarding sees x0 and no control side effects.
    localparam ex_stage_t EX_BUBBLE = '0;

    ex_stage_t       ex_q, ex_d, id_slot;
    ctrl_t           id_ctrl;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            stall;

    load_use_detector u_lud (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.ctrl.mem_read),
        .ex_rd_addr_i  (ex_q.rd_addr),
        .id_valid_i    (id_valid_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .flush_i       (flush_i),
        .stall_o       (stall)
    );

    always_comb begin
        id_ctrl = '{reg_write:  id_reg_write_i,
                    mem_read:   id_mem_read_i,
                    mem_write:  id_mem_write_i,
                    mem_to_reg: id_mem_to_reg_i,
                    alu_src:    id_alu_src_i,
                    branch:     id_branch_i,
                    jump:       id_jump_i,
                    alu_op:     id_alu_op_i};
        id_slot = '{valid:    id_valid_i,
                    pc:       id_pc_i,
                    rs1_data: id_rs1_data_i,
                    rs2_data: id_rs2_data_i,
                    imm:      id_imm_i,
                    rs1_addr: id_rs1_addr_i,
                    rs2_addr: id_rs2_addr_i,
                    rd_addr:  id_rd_addr_i,
                    ctrl:     id_valid_i ? id_ctrl : kill_side_effects(id_ctrl)};
    end

    // Flush outranks hold so a redirect is never lost behind a memory freeze.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush_i) begin
            ex_d        = EX_BUBBLE;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (hold_i) begin
            ex_d = ex_q;
        end else if (stall) begin
            ex_d         = EX_BUBBLE;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            ex_d = id_slot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q         <= EX_BUBBLE;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid_o       = ex_q.valid;
    assign ex_pc_o          = ex_q.pc;
    assign ex_rs1_data_o    = ex_q.rs1_data;
    assign ex_rs2_data_o    = ex_q.rs2_data;
    assign ex_imm_o         = ex_q.imm;
    assign ex_rs1_addr_o    = ex_q.rs1_addr;
    assign ex_rs2_addr_o    = ex_q.rs2_addr;
    assign ex_rd_addr_o     = ex_q.rd_addr;
    assign ex_reg_write_o   = ex_q.ctrl.reg_write;
    assign ex_mem_read_o    = ex_q.ctrl.mem_read;
    assign ex_mem_write_o   = ex_q.ctrl.mem_write;
    assign ex_mem_to_reg_o  = ex_q.ctrl.mem_to_reg;
    assign ex_alu_src_o     = ex_q.ctrl.alu_src;
    assign ex_branch_o      = ex_q.ctrl.branch;
    assign ex_jump_o        = ex_q.ctrl.jump;
    assign ex_alu_op_o      = ex_q.ctrl.alu_op;

    assign load_use_stall_o = stall;
    assign pc_write_o       = ~(hold_i | stall);
    assign if_id_write_o    = ~(hold_i | stall);
    assign bubble_count_o   = bubble_cnt_q;
    assign flush_count_o    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: a 32-bit-counter instance plus a 4-bit-counter
// instance driven by the same stimulus for the wrap case.
module tb_id_ex_hazard_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hold, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump;
    logic [3:0]  id_alu_op;

    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [3:0]  ex_alu_op;
    logic        stall, pc_write, if_id_write;
    logic [31:0] bubble_count, flush_count;

    logic        s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, s_ex_alu_src, s_ex_branch, s_ex_jump;
    logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [4:0]  s_ex_rs1_addr, s_ex_rs2_addr, s_ex_rd_addr;
    logic [3:0]  s_ex_alu_op;
    logic        s_stall, s_pc_write, s_if_id_write;
    logic [3:0]  s_bubble_count, s_flush_count;

    int checks   = 0;
    int failures = 0;

    id_ex_hazard_reg #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
        .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
        .id_mem_to_reg_i(id_mem_to_reg), .id_alu_src_i(id_alu_src), .id_branch_i(id_branch),
        .id_jump_i(id_jump), .id_alu_op_i(id_alu_op),
        .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
        .ex_imm_o(ex_imm), .ex_rs1_addr_o(ex_rs1_addr), .ex_rs2_addr_o(ex_rs2_addr), .ex_rd_addr_o(ex_rd_addr),
        .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
        .ex_mem_to_reg_o(ex_mem_to_reg), .ex_alu_src_o(ex_alu_src), .ex_branch_o(ex_branch),
        .ex_jump_o(ex_jump), .ex_alu_op_o(ex_alu_op),
        .load_use_stall_o(stall), .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .bubble_count_o(bubble_count), .flush_count_o(flush_count)
    );

    id_ex_hazard_reg #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
        .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
        .id_mem_to_reg_i(id_mem_to_reg), .id_alu_src_i(id_alu_src), .id_branch_i(id_branch),
        .id_jump_i(id_jump), .id_alu_op_i(id_alu_op),
        .ex_valid_o(s_ex_valid), .ex_pc_o(s_ex_pc), .ex_rs1_data_o(s_ex_rs1_data), .ex_rs2_data_o(s_ex_rs2_data),
        .ex_imm_o(s_ex_imm), .ex_rs1_addr_o(s_ex_rs1_addr), .ex_rs2_addr_o(s_ex_rs2_addr), .ex_rd_addr_o(s_ex_rd_addr),
        .ex_reg_write_o(s_ex_reg_write), .ex_mem_read_o(s_ex_mem_read), .ex_mem_write_o(s_ex_mem_write),
        .ex_mem_to_reg_o(s_ex_mem_to_reg), .ex_alu_src_o(s_ex_alu_src), .ex_branch_o(s_ex_branch),
        .ex_jump_o(s_ex_jump), .ex_alu_op_o(s_ex_alu_op),
        .load_use_stall_o(s_stall), .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write),
        .bubble_count_o(s_bubble_count), .flush_count_o(s_flush_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_alu_src = 0; id_branch = 0; id_jump = 0; id_alu_op = '0;
    endtask

    task automatic id_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
        id_clear();
        id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_uses_rs1 = 1; id_rd_addr = rd;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h4;
    endtask

    task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc);
        id_clear();
        id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_reg_write = 1; id_alu_op = 4'd1;
        id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    endtask

    initial begin
        rst = 1; hold = 0; flush = 0;
        id_clear();
        id_valid = 1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom); id_rd_addr = 5'($urandom);
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_alu_op = 4'($urandom);
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd", ex_rd_addr, 0);
        chk("rst_ex_mem_read", ex_mem_read, 0);
        chk("rst_ex_alu_op", ex_alu_op, 0);
        chk("rst_bubble", bubble_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_pc_write", pc_write, 1);

        // lw x5 then dependent add
        rst = 0;
        id_load(5'd5, 5'd2, 32'h100);
        tick();
        chk("lw_ex_mem_read", ex_mem_read, 1);
        chk("lw_ex_rd", ex_rd_addr, 5);
        chk("lw_ex_pc", ex_pc, 32'h100);
        id_alu(5'd6, 5'd5, 5'd3, 32'h104);
        settle();
        chk("lu_stall", stall, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_mem_read", ex_mem_read, 0);
        chk("lu_bubble_rd", ex_rd_addr, 0);
        chk("lu_bubble_count", bubble_count, 1);
        chk("lu_stall_drops", stall, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rs1", ex_rs1_addr, 5);
        chk("lu_add_rd", ex_rd_addr, 6);
        chk("lu_add_rs1_data", ex_rs1_data, 32'h11);
        chk("lu_add_bubble_count", bubble_count, 1);

        // no false stalls: unused rs2, and load to x0
        id_load(5'd5, 5'd2, 32'h200);
        tick();
        id_alu(5'd4, 5'd1, 5'd5, 32'h204);
        id_uses_rs2 = 0;
        settle();
        chk("nfs_rs2_unused_stall", stall, 0);
        chk("nfs_rs2_unused_pc_write", pc_write, 1);
        id_load(5'd0, 5'd2, 32'h208);
        tick();
        id_alu(5'd4, 5'd0, 5'd0, 32'h20c);
        settle();
        chk("nfs_x0_stall", stall, 0);

        // invalid ID slot: side-effect controls forced low
        id_clear();
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        id_alu_op = 4'd3; id_rd_addr = 5'd9;
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_reg_write", ex_reg_write, 0);
        chk("inv_mem_read", ex_mem_read, 0);
        chk("inv_mem_write", ex_mem_write, 0);
        chk("inv_mem_to_reg", ex_mem_to_reg, 1);
        chk("inv_rd", ex_rd_addr, 9);
        chk("inv_alu_op", ex_alu_op, 3);

        // flush with a hazard present
        id_load(5'd7, 5'd2, 32'h300);
        tick();
        id_alu(5'd8, 5'd7, 5'd1, 32'h304);
        flush = 1;
        settle();
        chk("fl_stall", stall, 0);
        chk("fl_pc_write", pc_write, 1);
        tick();
        flush = 0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_rs1_addr", ex_rs1_addr, 0);
        chk("fl_flush_count", flush_count, 1);
        chk("fl_bubble_count", bubble_count, 1);

        // hold with a hazard: frozen 3 cycles, then one bubble
        id_load(5'd8, 5'd2, 32'h400);
        tick();
        id_alu(5'd9, 5'd1, 5'd8, 32'h404);
        hold = 1;
        settle();
        chk("hold_stall", stall, 1);
        chk("hold_pc_write", pc_write, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd", ex_rd_addr, 8);
            chk("hold_mem_read", ex_mem_read, 1);
            chk("hold_bubble_count", bubble_count, 1);
        end
        hold = 0;
        tick();
        chk("hold_rel_valid", ex_valid, 0);
        chk("hold_rel_bubble_count", bubble_count, 2);
        tick();
        chk("hold_add_rd", ex_rd_addr, 9);
        chk("hold_add_rs2", ex_rs2_addr, 8);

        // back-to-back dependent loads
        id_load(5'd10, 5'd2, 32'h500);
        tick();
        id_load(5'd11, 5'd10, 32'h504);
        settle();
        chk("b2b_stall1", stall, 1);
        tick();
        chk("b2b_bubble_count", bubble_count, 3);
        tick();
        chk("b2b_lw2_rs1", ex_rs1_addr, 10);
        chk("b2b_lw2_rd", ex_rd_addr, 11);
        id_alu(5'd12, 5'd11, 5'd0, 32'h508);
        settle();
        chk("b2b_stall2", stall, 1);

        // reset mid-stall
        rst = 1;
        tick();
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_mem_read", ex_mem_read, 0);
        chk("rst_mid_bubble", bubble_count, 0);
        chk("rst_mid_pc_write", pc_write, 1);

        // 17 flushes: 4-bit counter wraps to 1
        rst = 0;
        id_clear();
        flush = 1;
        for (int i = 0; i < 17; i++) tick();
        flush = 0;
        chk("wrap_small_flush", s_flush_count, 1);
        chk("wrap_big_flush", flush_count, 17);
        chk("wrap_small_bubble", s_bubble_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. Captures decoded operands and control from ID each cycle and presents the EX-side fields; its rs/rd addresses and reg_write feed the forwarding unit and the EX/MEM register. A load in EX whose rd matches a source register of the instruction in ID holds IF/ID and the PC for one cycle and inserts a bubble. The block also keeps wrapping performance counters for bubbles and flushes.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, width of performance counters
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- hold  in  1  global freeze from the memory stage; register and counters keep their values
- flush  in  1  taken branch or jump resolved in EX; the next ID/EX content is a bubble
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded data
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register addresses
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1 each  control
- id_alu_op  in  4  ALU operation, encoding from constants.v
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered data
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each  registered; feed the forwarding unit
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump  out  1 each
- ex_alu_op  out  4
- load_use_stall  out  1  combinational hazard flag
- pc_write, if_id_write  out  1 each  enables for the PC and the IF/ID register
- bubble_count, flush_count  out  CNT_W each  performance counters

## Operation
- Hazard, combinational from registered EX state and current ID inputs:
  - load_use_stall = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
  - load_use_stall is forced to 0 when flush=1.
- pc_write = if_id_write = ~(hold | load_use_stall). A flush does not gate these, because the PC is being redirected.
- Next-state priority, evaluated at each rising edge:
  1. rst: clear all registers.
  2. flush: load a bubble; flush_count += 1.
  3. hold: keep all registers; counters unchanged.
  4. load_use_stall: load a bubble; bubble_count += 1.
  5. Otherwise: capture all id_* fields; ex_valid = id_valid.
- Bubble: ex_valid=0, every control output 0, all three addresses 0 (the forwarding unit then sees x0), data and pc fields 0.
- An instruction with id_valid=0 is captured as-is except that reg_write, mem_read and mem_write are forced to 0.
- Counters wrap modulo 2^CNT_W.

## Timing
- Latency: one cycle from id_* to ex_*. Hazard outputs are valid in the same cycle as the ID inputs.
- Reset value of every registered output is 0. After reset, pc_write=if_id_write=1 unless hold=1.
- Reset asserted mid-stall clears the EX load, so the stall drops in the following cycle.
- A load-use stall lasts exactly one cycle:
  - The bubble clears ex_mem_read.
  - The load then sits in MEM, and the forwarding unit supplies its result from MEM/WB on the next cycle.
- hold=1 together with a hazard: nothing is loaded and the hazard persists. The bubble is inserted on the first cycle with hold=0.
- flush=1 together with a hazard: a single bubble is inserted (flush takes priority), only flush_count increments, and pc_write=1.
- A load with rd=x0 never stalls.
- Back-to-back loads where the second depends on the first stall once per dependent pair.

## Structure
- constants.v holds the ALU_OP encodings, the bubble/NOP control vector and the forwarding codes (00 none, 01 EX, 10 MEM). Do not duplicate these locally.
- One natural sub-module, load_use_detector, which is purely combinational and contains the stall equation. The register, priority logic and counters stay in the top module.

## Test plan
- Reset: assert rst for 2 cycles with random id_* -> all ex_* outputs 0, both counters 0, pc_write=1.
- Load-use on rs1: EX holds lw x5 (mem_read=1, rd=5); ID holds add using rs1=5 -> load_use_stall=1 and pc_write=0 that cycle; next cycle ex_valid=0 and ex_mem_read=0; bubble_count=1; the add enters EX one cycle later with ex_rs1_addr=5.
- No false stall:
  - Load rd=5, ID rs2=5 with id_uses_rs2=0 -> stall=0.
  - Load rd=0, ID rs1=0 -> stall=0.
- Flush with hazard: lw x7 in EX, ID reads x7, flush=1 -> stall=0, pc_write=1, next ex_valid=0, flush_count=1, bubble_count unchanged.
- Hold: a hazard present with hold=1 for 3 cycles -> ex_* stable and counters stable; release -> one bubble, bubble_count=1.
- Counter wrap: with CNT_W=4, 17 flush cycles -> flush_count=1.
